// File: rtl/mips_dcache.sv
// Direct-mapped, write-back, write-allocate data cache with one 32-bit word per line.
// Misses, evictions and the halt-time flush of dirty lines go through an mm_req/mm_ack handshake.
module mips_dcache #(
  parameter int INDEX_BITS = 4,
  localparam int TAG_BITS = 32 - INDEX_BITS - 2
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            core_req,
  input  logic [31:0]     mem_addr,
  input  logic [3:0][7:0] mem_data_in,
  input  logic            mem_write_en,
  output logic [3:0][7:0] mem_data_out,
  output logic            core_stall,
  input  logic            flush_req,
  output logic            flush_done,
  output logic            mm_req,
  output logic            mm_we,
  output logic [31:0]     mm_addr,
  output logic [31:0]     mm_wdata,
  input  logic [31:0]     mm_rdata,
  input  logic            mm_ack,
  output logic [2:0]      dbg_state
);
  localparam int NUM_LINES = 1 << INDEX_BITS;

  typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH_SCAN, FLUSH_WB, DONE} state_t;

  // Backing-memory handshake: mm_req rises with mm_we/mm_addr/mm_wdata already valid,
  // all four hold steady until the single-cycle mm_ack; fill data is taken in that ack cycle.
  logic [31:0]           data_q [NUM_LINES];
  logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0]  valid_q, dirty_q;

  state_t                state, state_n;
  logic [INDEX_BITS:0]   cnt, cnt_n;
  logic [INDEX_BITS-1:0] req_idx, req_idx_n;
  logic [TAG_BITS-1:0]   req_tag, req_tag_n;
  logic                  mm_req_n, mm_we_n;
  logic [31:0]           mm_addr_n, mm_wdata_n;

  logic [INDEX_BITS-1:0] idx, scan_idx, clr_idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit, store_we, fill_we, dirty_clr;
  logic                  addr_lsb_unused;

  assign idx             = mem_addr[INDEX_BITS+1:2];
  assign tag             = mem_addr[31:INDEX_BITS+2];
  assign addr_lsb_unused = ^mem_addr[1:0];
  assign hit             = core_req & valid_q[idx] & (tag_q[idx] == tag);
  assign scan_idx        = cnt[INDEX_BITS-1:0];
  assign mem_data_out    = (state == IDLE && hit) ? data_q[idx] : '0;
  assign flush_done      = (state == DONE);
  assign dbg_state       = state;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    req_idx_n  = req_idx;
    req_tag_n  = req_tag;
    mm_req_n   = mm_req;
    mm_we_n    = mm_we;
    mm_addr_n  = mm_addr;
    mm_wdata_n = mm_wdata;
    core_stall = 1'b1;
    store_we   = 1'b0;
    fill_we    = 1'b0;
    dirty_clr  = 1'b0;
    clr_idx    = req_idx;
    case (state)
      IDLE: begin
        core_stall = core_req & (flush_req | ~hit);
        if (flush_req) begin
          // A halted core's flush wins over any access presented alongside it.
          state_n = FLUSH_SCAN;
          cnt_n   = '0;
        end else if (hit) begin
          store_we = mem_write_en;
        end else if (core_req) begin
          req_idx_n = idx;
          req_tag_n = tag;
          mm_req_n  = 1'b1;
          if (valid_q[idx] & dirty_q[idx]) begin
            state_n    = WB;
            mm_we_n    = 1'b1;
            mm_addr_n  = {tag_q[idx], idx, 2'b00};
            mm_wdata_n = data_q[idx];
          end else begin
            state_n   = FILL;
            mm_we_n   = 1'b0;
            mm_addr_n = {tag, idx, 2'b00};
          end
        end
      end
      WB: if (mm_ack) begin
        dirty_clr = 1'b1;
        state_n   = FILL;
        mm_we_n   = 1'b0;
        mm_addr_n = {req_tag, req_idx, 2'b00};
      end
      FILL: if (mm_ack) begin
        fill_we  = 1'b1;
        state_n  = IDLE;
        mm_req_n = 1'b0;
      end
      FLUSH_SCAN: begin
        if (valid_q[scan_idx] & dirty_q[scan_idx]) begin
          state_n    = FLUSH_WB;
          mm_req_n   = 1'b1;
          mm_we_n    = 1'b1;
          mm_addr_n  = {tag_q[scan_idx], scan_idx, 2'b00};
          mm_wdata_n = data_q[scan_idx];
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt_n[INDEX_BITS]) state_n = DONE;
        end
      end
      FLUSH_WB: if (mm_ack) begin
        dirty_clr = 1'b1;
        clr_idx   = scan_idx;
        mm_req_n  = 1'b0;
        mm_we_n   = 1'b0;
        cnt_n     = cnt + 1'b1;
        state_n   = cnt_n[INDEX_BITS] ? DONE : FLUSH_SCAN;
      end
      DONE: if (!flush_req) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state    <= IDLE;
      cnt      <= '0;
      req_idx  <= '0;
      req_tag  <= '0;
      mm_req   <= 1'b0;
      mm_we    <= 1'b0;
      mm_addr  <= '0;
      mm_wdata <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      req_idx  <= req_idx_n;
      req_tag  <= req_tag_n;
      mm_req   <= mm_req_n;
      mm_we    <= mm_we_n;
      mm_addr  <= mm_addr_n;
      mm_wdata <= mm_wdata_n;
      if (fill_we) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
      if (store_we) dirty_q[idx] <= 1'b1;
      if (dirty_clr) dirty_q[clr_idx] <= 1'b0;
    end
  end

  // Line payload needs no reset: valid_q gates every use of it.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[req_idx] <= mm_rdata;
      tag_q[req_idx]  <= req_tag;
    end
    if (store_we) data_q[idx] <= mem_data_in;
  end
endmodule

// File: tb/tb_mips_dcache.sv
// Bench for mips_dcache: directed scenarios plus randomized traffic checked against
// a transparent-memory model with a 16-entry residency map.
module tb_mips_dcache;
  logic            clk = 1'b0;
  logic            rst_b = 1'b1;
  logic            core_req = 1'b0, mem_write_en = 1'b0, flush_req = 1'b0;
  logic [31:0]     mem_addr = '0;
  logic [3:0][7:0] mem_data_in = '0;
  logic [3:0][7:0] mem_data_out;
  logic            core_stall, flush_done, mm_req, mm_we;
  logic [31:0]     mm_addr, mm_wdata;
  logic [31:0]     mm_rdata = '0;
  logic            mm_ack = 1'b0;
  logic [2:0]      dbg_state;

  int checks = 0;
  int failures = 0;

  mips_dcache dut (
    .clk(clk), .rst_b(rst_b), .core_req(core_req), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_write_en(mem_write_en), .mem_data_out(mem_data_out),
    .core_stall(core_stall), .flush_req(flush_req), .flush_done(flush_done),
    .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
    .mm_rdata(mm_rdata), .mm_ack(mm_ack), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- backing memory responder ----------------
  logic [31:0] mem [logic [31:0]];
  logic [64:0] obs_q[$];   // {we, addr, wdata-or-0} per completed transfer
  logic [64:0] exp_q[$];
  int lat = 1;
  int wait_cnt = 0;
  bit ack_block = 1'b0;

  function automatic logic [31:0] backing(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ((a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A);
  endfunction

  always @(negedge clk) begin
    if (rst_b || mm_ack || !mm_req) begin
      mm_ack = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= lat && !ack_block) begin
      mm_ack = 1'b1;
      if (mm_we) begin
        mem[mm_addr] = mm_wdata;
        obs_q.push_back({1'b1, mm_addr, mm_wdata});
      end else begin
        mm_rdata = backing(mm_addr);
        obs_q.push_back({1'b0, mm_addr, 32'h0});
      end
    end else begin
      wait_cnt++;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] view [logic [31:0]];   // words stored by the core since the last reset
  logic [31:0] line_addr [16];
  bit          line_valid [16];
  bit          line_dirty [16];

  function automatic logic [31:0] core_view(input logic [31:0] a);
    return view.exists(a) ? view[a] : backing(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      line_valid[i] = 1'b0;
      line_dirty[i] = 1'b0;
    end
    view.delete();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic model_access(input logic [31:0] a, input bit we, input logic [31:0] wd);
    int i;
    i = int'(a[5:2]);
    if (!(line_valid[i] && line_addr[i] == a)) begin
      if (line_valid[i] && line_dirty[i]) exp_q.push_back({1'b1, line_addr[i], core_view(line_addr[i])});
      exp_q.push_back({1'b0, a, 32'h0});
      line_valid[i] = 1'b1;
      line_addr[i] = a;
      line_dirty[i] = 1'b0;
    end
    if (we) begin
      line_dirty[i] = 1'b1;
      view[a] = wd;
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < 16; i++)
      if (line_valid[i] && line_dirty[i]) begin
        exp_q.push_back({1'b1, line_addr[i], core_view(line_addr[i])});
        line_dirty[i] = 1'b0;
      end
  endtask

  // ---------------- driver ----------------
  task automatic access(input logic [31:0] a, input bit we, input logic [31:0] wd,
                        output logic [31:0] rd, output int stalls);
    @(negedge clk);
    core_req = 1'b1;
    mem_addr = a;
    mem_write_en = we;
    mem_data_in = wd;
    stalls = 0;
    #1;
    while (core_stall === 1'b1 && stalls < 200) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    rd = mem_data_out;
    @(posedge clk);
    #1;
    core_req = 1'b0;
    mem_write_en = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (mm_req !== 1'b0) begin failures++; $display("FAIL reset_mm_req got=%0b exp=0", mm_req); end
    checks++; if (mm_we !== 1'b0) begin failures++; $display("FAIL reset_mm_we got=%0b exp=0", mm_we); end
    checks++; if (mm_addr !== 32'h0) begin failures++; $display("FAIL reset_mm_addr got=%h exp=0", mm_addr); end
    checks++; if (mm_wdata !== 32'h0) begin failures++; $display("FAIL reset_mm_wdata got=%h exp=0", mm_wdata); end
    checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL reset_flush_done got=%0b exp=0", flush_done); end
    checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL reset_core_stall got=%0b exp=0", core_stall); end
    checks++; if (mem_data_out !== 32'h0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", mem_data_out); end
    @(negedge clk);
    rst_b = 1'b0;
    model_reset();
  endtask

  task automatic test_fill();
    int n;
    obs_q.delete();
    mem[32'h40] = 32'h1122_3344;
    lat = 2;
    @(negedge clk);
    core_req = 1'b1; mem_addr = 32'h40; mem_write_en = 1'b0;
    #1;
    checks++; if (core_stall !== 1'b1) begin failures++; $display("FAIL fill_stall_same_cycle got=%0b exp=1", core_stall); end
    @(negedge clk);
    #1;
    checks++; if ({mm_req, mm_we, mm_addr} !== {1'b1, 1'b0, 32'h40}) begin
      failures++; $display("FAIL fill_request got req=%0b we=%0b addr=%h exp req=1 we=0 addr=40", mm_req, mm_we, mm_addr);
    end
    checks++; if (core_stall !== 1'b1) begin failures++; $display("FAIL fill_stall_wait got=%0b exp=1", core_stall); end
    n = 0;
    while (core_stall === 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    checks++; if (n >= 50) begin failures++; $display("FAIL fill_timeout got=%0d cycles exp=<50", n); end
    checks++; if (mem_data_out !== 32'h1122_3344) begin failures++; $display("FAIL fill_data got=%h exp=11223344", mem_data_out); end
    checks++; if (mem_data_out[0] !== 8'h44) begin failures++; $display("FAIL fill_byte0 got=%h exp=44", mem_data_out[0]); end
    checks++; if (obs_q.size() != 1 || obs_q[0] !== {1'b0, 32'h40, 32'h0}) begin
      failures++; $display("FAIL fill_traffic got count=%0d first=%h exp one read of 40", obs_q.size(), obs_q[0]);
    end
    @(posedge clk);
    #1;
    core_req = 1'b0;
    lat = 1;
  endtask

  task automatic test_store_hit();
    logic [31:0] rd;
    int st;
    obs_q.delete();
    access(32'h40, 1'b1, 32'hDEAD_BEEF, rd, st);
    checks++; if (st != 0) begin failures++; $display("FAIL store_hit_stall got=%0d exp=0", st); end
    access(32'h40, 1'b0, 32'h0, rd, st);
    checks++; if (st != 0) begin failures++; $display("FAIL load_hit_stall got=%0d exp=0", st); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL store_readback got=%h exp=deadbeef", rd); end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL hit_traffic got=%0d exp=0", obs_q.size()); end
  endtask

  task automatic test_evict();
    logic [31:0] rd;
    int st;
    obs_q.delete();
    access(32'h440, 1'b0, 32'h0, rd, st);
    checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL evict_count got=%0d exp=2", obs_q.size()); end
    checks++; if (obs_q[0] !== {1'b1, 32'h40, 32'hDEAD_BEEF}) begin failures++; $display("FAIL evict_wb got=%h exp=%h", obs_q[0], {1'b1, 32'h40, 32'hDEAD_BEEF}); end
    checks++; if (obs_q[1] !== {1'b0, 32'h440, 32'h0}) begin failures++; $display("FAIL evict_fill got=%h exp=%h", obs_q[1], {1'b0, 32'h440, 32'h0}); end
    checks++; if (rd !== backing(32'h440)) begin failures++; $display("FAIL evict_data got=%h exp=%h", rd, backing(32'h440)); end
  endtask

  task automatic test_wb_stall();
    logic [31:0] rd;
    int st, n;
    access(32'h80, 1'b1, 32'hCAFE_0001, rd, st);
    obs_q.delete();
    ack_block = 1'b1;
    @(negedge clk);
    core_req = 1'b1; mem_addr = 32'h480; mem_write_en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({mm_req, mm_we, mm_addr, mm_wdata, core_stall} !== {1'b1, 1'b1, 32'h80, 32'hCAFE_0001, 1'b1}) begin
        failures++;
        $display("FAIL wb_hold cyc=%0d got req=%0b we=%0b addr=%h wdata=%h stall=%0b exp 1 1 80 cafe0001 1",
                 c, mm_req, mm_we, mm_addr, mm_wdata, core_stall);
      end
    end
    ack_block = 1'b0;
    n = 0;
    #1;
    while (core_stall === 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    rd = mem_data_out;
    @(posedge clk);
    #1;
    core_req = 1'b0;
    checks++; if (rd !== backing(32'h480)) begin failures++; $display("FAIL wb_hold_data got=%h exp=%h", rd, backing(32'h480)); end
    checks++; if (obs_q.size() != 2 || obs_q[0] !== {1'b1, 32'h80, 32'hCAFE_0001} || obs_q[1] !== {1'b0, 32'h480, 32'h0}) begin
      failures++; $display("FAIL wb_hold_traffic got count=%0d first=%h exp wb 80 then fill 480", obs_q.size(), obs_q[0]);
    end
  endtask

  task automatic test_flush();
    logic [31:0] rd, d0, d3, d15;
    int st, n;
    bit stall_drop;
    d0 = $urandom; d3 = $urandom; d15 = $urandom;
    access(32'h100, 1'b1, d0, rd, st);
    access(32'h10C, 1'b1, d3, rd, st);
    access(32'h13C, 1'b1, d15, rd, st);
    access(32'h114, 1'b0, 32'h0, rd, st);
    obs_q.delete();
    @(negedge clk);
    flush_req = 1'b1; core_req = 1'b1; mem_addr = 32'h100; mem_write_en = 1'b0;
    #1;
    stall_drop = (core_stall !== 1'b1);
    n = 0;
    while (flush_done !== 1'b1 && n < 500) begin
      @(negedge clk); #1; n++;
      if (core_stall !== 1'b1) stall_drop = 1'b1;
    end
    checks++; if (flush_done !== 1'b1) begin failures++; $display("FAIL flush_done got=%0b exp=1", flush_done); end
    checks++; if (stall_drop) begin failures++; $display("FAIL flush_stall got=dropped exp=held"); end
    checks++; if (obs_q.size() != 3) begin failures++; $display("FAIL flush_count got=%0d exp=3", obs_q.size()); end
    checks++; if (obs_q[0] !== {1'b1, 32'h100, d0}) begin failures++; $display("FAIL flush_wb0 got=%h exp=%h", obs_q[0], {1'b1, 32'h100, d0}); end
    checks++; if (obs_q[1] !== {1'b1, 32'h10C, d3}) begin failures++; $display("FAIL flush_wb3 got=%h exp=%h", obs_q[1], {1'b1, 32'h10C, d3}); end
    checks++; if (obs_q[2] !== {1'b1, 32'h13C, d15}) begin failures++; $display("FAIL flush_wb15 got=%h exp=%h", obs_q[2], {1'b1, 32'h13C, d15}); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({flush_done, core_stall} !== 2'b11) begin failures++; $display("FAIL flush_hold got done=%0b stall=%0b exp 1 1", flush_done, core_stall); end
    @(negedge clk);
    flush_req = 1'b0;
    n = 0;
    #1;
    while (core_stall === 1'b1 && n < 10) begin @(negedge clk); #1; n++; end
    rd = mem_data_out;
    @(posedge clk);
    #1;
    core_req = 1'b0;
    checks++; if (rd !== d0) begin failures++; $display("FAIL flush_line_kept got=%h exp=%h", rd, d0); end
    checks++; if (obs_q.size() != 3) begin failures++; $display("FAIL flush_no_refill got=%0d exp=3", obs_q.size()); end
    obs_q.delete();
    @(negedge clk);
    flush_req = 1'b1;
    n = 0;
    #1;
    while (flush_done !== 1'b1 && n < 500) begin @(negedge clk); #1; n++; end
    checks++; if (flush_done !== 1'b1) begin failures++; $display("FAIL flush2_done got=%0b exp=1", flush_done); end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL flush2_traffic got=%0d exp=0", obs_q.size()); end
    @(negedge clk);
    flush_req = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL flush_exit got=%0b exp=0", flush_done); end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] rd;
    int st;
    obs_q.delete();
    ack_block = 1'b1;
    @(negedge clk);
    core_req = 1'b1; mem_addr = 32'h200; mem_write_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({mm_req, mm_we, mm_addr} !== {1'b1, 1'b0, 32'h200}) begin
      failures++; $display("FAIL midfill_req got req=%0b we=%0b addr=%h exp 1 0 200", mm_req, mm_we, mm_addr);
    end
    #1;
    rst_b = 1'b1;
    #1;
    checks++; if ({mm_req, mm_addr} !== {1'b0, 32'h0}) begin
      failures++; $display("FAIL async_reset got req=%0b addr=%h exp 0 0", mm_req, mm_addr);
    end
    core_req = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    ack_block = 1'b0;
    model_reset();
    access(32'h200, 1'b0, 32'h0, rd, st);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== {1'b0, 32'h200, 32'h0}) begin
      failures++; $display("FAIL post_reset_miss got count=%0d first=%h exp one read of 200", obs_q.size(), obs_q[0]);
    end
    checks++; if (rd !== backing(32'h200)) begin failures++; $display("FAIL post_reset_data got=%h exp=%h", rd, backing(32'h200)); end
    access(32'h10C, 1'b0, 32'h0, rd, st);
    checks++; if (rd !== mem[32'h10C]) begin failures++; $display("FAIL flushed_word_persists got=%h exp=%h", rd, mem[32'h10C]); end
  endtask

  task automatic test_random();
    logic [25:0] tag_tab [4];
    logic [31:0] a, wd, rd, exp_rd;
    bit we;
    int st, n;
    tag_tab = '{26'h0, 26'h1, 26'h3FF_FFFF, 26'h200_0000};
    pulse_reset();
    for (int it = 0; it < 400; it++) begin
      lat = $urandom_range(0, 3);
      if (it % 60 == 59) begin
        model_flush();
        @(negedge clk);
        flush_req = 1'b1;
        n = 0;
        #1;
        while (flush_done !== 1'b1 && n < 500) begin @(negedge clk); #1; n++; end
        checks++; if (flush_done !== 1'b1) begin failures++; $display("FAIL rand_flush_done it=%0d got=%0b exp=1", it, flush_done); end
        @(negedge clk);
        flush_req = 1'b0;
        @(negedge clk);
      end else begin
        a = {tag_tab[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'b00};
        we = 1'($urandom_range(0, 1));
        wd = $urandom;
        exp_rd = core_view(a);
        model_access(a, we, wd);
        access(a | 32'($urandom_range(0, 3)), we, wd, rd, st);
        checks++; if (st >= 200) begin failures++; $display("FAIL rand_timeout it=%0d got=%0d exp=<200", it, st); end
        if (!we) begin
          checks++; if (rd !== exp_rd) begin failures++; $display("FAIL rand_load it=%0d addr=%h got=%h exp=%h", it, a, rd, exp_rd); end
        end
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        failures++; $display("FAIL rand_traffic_count it=%0d got=%0d exp=%0d", it, obs_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[k]) begin
          checks++;
          if (obs_q[k] !== exp_q[k]) begin failures++; $display("FAIL rand_traffic it=%0d k=%0d got=%h exp=%h", it, k, obs_q[k], exp_q[k]); end
        end
      end
      obs_q.delete();
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_store_hit();
    test_evict();
    test_wb_stall();
    test_flush();
    test_reset_mid_fill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
